cdb_arbiter: RTL and testbench

//  Writeback stage directly downstream of the alu, add and mul execute units.

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result inputs and CDB broadcast outputs of the writeback arbiter
interface cdb_arbiter_if #(
    parameter int NUM_FU = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int PC_W   = 32,
    parameter int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
    logic                     flush;
    logic                     wb_stall;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*PC_W-1:0]   fu_pc;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [DATA_W-1:0]        cdb_data;
    logic [TAG_W-1:0]         cdb_tag;
    logic [PC_W-1:0]          cdb_pc;
    logic [SRC_W-1:0]         cdb_src;

    modport master (
        output flush, wb_stall, fu_valid, fu_data, fu_tag, fu_pc,
        input  fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_pc, cdb_src
    );

    modport slave (
        input  flush, wb_stall, fu_valid, fu_data, fu_tag, fu_pc,
        output fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_pc, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result FIFOs round-robin arbitrated onto the common data bus
module cdb_fu_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         not_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          do_pop;

    // Ready looks only at the registered count; a same-cycle pop does not free a slot.
    assign push_ready = !rst && (count < CW'(DEPTH));
    assign push       = push_valid && push_ready && !flush;
    assign do_pop     = pop && not_empty;
    assign not_empty  = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_FU = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int ENT_W = PC_W + TAG_W + DATA_W;

    logic [ENT_W-1:0]  head [NUM_FU];
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] pop_sel;
    logic [NUM_FU-1:0] ready_v;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  rr_next;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  scan_idx;
    logic              grant_any;
    logic              grant_fire;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_fu_fifo #(
            .W     (ENT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (bus.flush),
            .push_valid (bus.fu_valid[i]),
            .push_data  ({bus.fu_pc[i*PC_W +: PC_W],
                          bus.fu_tag[i*TAG_W +: TAG_W],
                          bus.fu_data[i*DATA_W +: DATA_W]}),
            .push_ready (ready_v[i]),
            .pop        (pop_sel[i]),
            .head_data  (head[i]),
            .not_empty  (cand[i])
        );

        assign pop_sel[i] = grant_fire && (grant_idx == SRC_W'(i));
    end

    assign bus.fu_ready = ready_v;

    // First non-empty FIFO at or after rr_ptr, wrapping modulo NUM_FU.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = SRC_W'((int'(rr_ptr) + k) % NUM_FU);
            if (!grant_any && cand[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_fire = grant_any && !bus.wb_stall && !bus.flush;
    assign rr_next    = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);

    // Broadcast fields hold their last value while idle; only cdb_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_data  <= '0;
            bus.cdb_tag   <= '0;
            bus.cdb_pc    <= '0;
            bus.cdb_src   <= '0;
        end else if (grant_fire) begin
            rr_ptr        <= rr_next;
            bus.cdb_valid <= 1'b1;
            {bus.cdb_pc, bus.cdb_tag, bus.cdb_data} <= head[grant_idx];
            bus.cdb_src   <= grant_idx;
        end else begin
            bus.cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a queue model
`timescale 1ns/1ps
module tb_cdb_arbiter;
    localparam int NUM_FU = 3;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .PC_W(PC_W)) bus ();

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .PC_W   (PC_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one queue per FU, a round-robin pointer, and the expected broadcast.
    ent_t       mq [NUM_FU][$];
    int         m_rr = 0;
    logic       e_valid = 1'b0;
    ent_t       e_ent = '0;
    logic [1:0] e_src = '0;

    function automatic logic [NUM_FU-1:0] exp_ready();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = !rst && (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_edge();
        bit   acc [NUM_FU];
        int   g;
        ent_t ent;
        for (int i = 0; i < NUM_FU; i++) acc[i] = !rst && bus.fu_valid[i] && (mq[i].size() < DEPTH);
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0; e_valid = 1'b0; e_ent = '0; e_src = '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            e_valid = 1'b0;
        end else begin
            g = -1;
            if (!bus.wb_stall)
                for (int k = 0; k < NUM_FU; k++)
                    if (g < 0 && mq[(m_rr + k) % NUM_FU].size() != 0) g = (m_rr + k) % NUM_FU;
            e_valid = (g >= 0);
            if (g >= 0) begin
                e_ent = mq[g].pop_front();
                e_src = 2'(g);
                m_rr  = (g + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    ent.pc   = bus.fu_pc[i*PC_W +: PC_W];
                    ent.tag  = bus.fu_tag[i*TAG_W +: TAG_W];
                    ent.data = bus.fu_data[i*DATA_W +: DATA_W];
                    mq[i].push_back(ent);
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fu(int i, bit v, logic [3:0] tag, logic [31:0] data, logic [31:0] pc);
        bus.fu_valid[i] = v;
        bus.fu_tag[i*TAG_W +: TAG_W]    = tag;
        bus.fu_data[i*DATA_W +: DATA_W] = data;
        bus.fu_pc[i*PC_W +: PC_W]       = pc;
    endtask

    task automatic idle();
        bus.fu_valid = '0;
        bus.flush    = 1'b0;
        bus.wb_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fu_data = '0; bus.fu_tag = '0; bus.fu_pc = '0;
        idle();
        tick(); tick();
        n_assert++;
        if (bus.fu_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready got %b exp 000", bus.fu_ready);
        end
        n_assert++;
        if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_cdb got v=%b d=%h t=%h pc=%h s=%0d exp all zero",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src);
        end
        rst = 1'b0;
        #1;
        n_assert++;
        if (bus.fu_ready !== 3'b111) begin
            n_fail++; $display("FAIL post_reset_ready got %b exp 111", bus.fu_ready);
        end
        tick();
    endtask

    task automatic test_single();
        drive_fu(0, 1'b1, 4'd5, 32'h1234_5678, 32'h100);
        tick();
        idle();
        n_assert++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early got %b exp 0", bus.cdb_valid);
        end
        tick();
        n_assert++;
        if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src} !==
            {1'b1, 32'h1234_5678, 4'd5, 32'h100, 2'd0}) begin
            n_fail++;
            $display("FAIL single_bcast got v=%b d=%h t=%0d pc=%h s=%0d exp v=1 d=12345678 t=5 pc=100 s=0",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src);
        end
        tick();
        n_assert++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_once got %b exp 0", bus.cdb_valid);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        for (int i = 0; i < NUM_FU; i++) drive_fu(i, 1'b1, 4'(i + 1), $urandom, $urandom);
        tick();
        idle();
        for (int c = 0; c < NUM_FU; c++) begin
            tick();
            n_assert++;
            if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_src} !== {1'b1, 4'(c + 1), 2'(c)}) begin
                n_fail++;
                $display("FAIL contention_%0d got v=%b t=%0d s=%0d exp v=1 t=%0d s=%0d",
                         c, bus.cdb_valid, bus.cdb_tag, bus.cdb_src, c + 1, c);
            end
        end
        tick();
        n_assert++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL contention_idle got %b exp 0", bus.cdb_valid);
        end
        // rr pointer has wrapped back to 0: FU0 must win over FU1
        drive_fu(0, 1'b1, 4'd10, $urandom, $urandom);
        drive_fu(1, 1'b1, 4'd11, $urandom, $urandom);
        tick(); idle(); tick();
        n_assert++;
        if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag} !== {1'b1, 2'd0, 4'd10}) begin
            n_fail++;
            $display("FAIL rr_wrap got v=%b s=%0d t=%0d exp v=1 s=0 t=10", bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
        end
        tick(); tick();
    endtask

    task automatic test_fairness();
        bit new_data [NUM_FU];
        int low_run [NUM_FU];
        int max_low = 0;
        int prev_src = -1;
        idle(); tick(); tick(); tick();
        for (int f = 0; f < NUM_FU; f++) begin new_data[f] = 1'b1; low_run[f] = 0; end
        for (int cyc = 0; cyc < 24; cyc++) begin
            for (int f = 0; f < NUM_FU; f += 2) begin
                if (new_data[f]) drive_fu(f, 1'b1, 4'($urandom), $urandom, $urandom);
                new_data[f] = bus.fu_ready[f];
            end
            tick();
            n_assert++;
            if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src} !==
                {e_valid, e_ent.data, e_ent.tag, e_ent.pc, e_src}) begin
                n_fail++;
                $display("FAIL fair_model cyc=%0d got v=%b t=%0d s=%0d exp v=%b t=%0d s=%0d",
                         cyc, bus.cdb_valid, bus.cdb_tag, bus.cdb_src, e_valid, e_ent.tag, e_src);
            end
            if (bus.cdb_valid) begin
                if (prev_src >= 0) begin
                    n_assert++;
                    if (int'(bus.cdb_src) == prev_src || bus.cdb_src == 2'd1) begin
                        n_fail++; $display("FAIL fair_alternate cyc=%0d got src %0d after %0d exp the other of 0/2",
                                           cyc, bus.cdb_src, prev_src);
                    end
                end
                prev_src = int'(bus.cdb_src);
            end
            for (int f = 0; f < NUM_FU; f += 2) begin
                low_run[f] = bus.fu_ready[f] ? 0 : low_run[f] + 1;
                if (low_run[f] > max_low) max_low = low_run[f];
            end
        end
        n_assert++;
        if (max_low > 1) begin
            n_fail++; $display("FAIL fair_starve got %0d consecutive not-ready cycles exp at most 1", max_low);
        end
        idle(); for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] got [$];
        bit pending = 1'b1;
        bit acc;
        idle(); tick(); tick();
        bus.wb_stall = 1'b1;
        drive_fu(1, 1'b1, 4'd7, 32'h7, 32'h70); tick();
        drive_fu(1, 1'b1, 4'd8, 32'h8, 32'h80); tick();
        drive_fu(1, 1'b1, 4'd9, 32'h9, 32'h90);
        n_assert++;
        if (bus.fu_ready[1] !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got %b exp 0", bus.fu_ready[1]);
        end
        tick(); tick();
        n_assert++;
        if ({bus.fu_ready[1], bus.cdb_valid} !== 2'b00) begin
            n_fail++; $display("FAIL bp_stalled got ready=%b valid=%b exp 0 0", bus.fu_ready[1], bus.cdb_valid);
        end
        bus.wb_stall = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            acc = pending && bus.fu_ready[1];
            tick();
            if (acc) begin pending = 1'b0; bus.fu_valid[1] = 1'b0; end
            if (bus.cdb_valid) got.push_back(bus.cdb_tag);
            n_assert++;
            if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_src} !== {e_valid, e_ent.tag, e_src}) begin
                n_fail++;
                $display("FAIL bp_model cyc=%0d got v=%b t=%0d exp v=%b t=%0d", cyc, bus.cdb_valid, bus.cdb_tag, e_valid, e_ent.tag);
            end
        end
        n_assert++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL bp_count got %0d broadcasts exp 3", got.size());
        end else begin
            n_assert++;
            if ({got[0], got[1], got[2]} !== {4'd7, 4'd8, 4'd9}) begin
                n_fail++; $display("FAIL bp_order got %0d,%0d,%0d exp 7,8,9", got[0], got[1], got[2]);
            end
        end
    endtask

    task automatic test_flush();
        idle(); tick(); tick();
        bus.wb_stall = 1'b1;
        drive_fu(2, 1'b1, 4'd12, $urandom, $urandom); tick();
        drive_fu(2, 1'b1, 4'd13, $urandom, $urandom); tick();
        bus.fu_valid = '0;
        bus.wb_stall = 1'b0;
        bus.flush = 1'b1;
        drive_fu(0, 1'b1, 4'd14, $urandom, $urandom);
        tick();
        idle();
        n_assert++;
        if ({bus.fu_ready, bus.cdb_valid} !== 4'b1110) begin
            n_fail++; $display("FAIL flush_state got ready=%b valid=%b exp 111 0", bus.fu_ready, bus.cdb_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_assert++;
            if (bus.cdb_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_quiet cyc=%0d got %b exp 0", i, bus.cdb_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NUM_FU; i++) drive_fu(i, 1'b1, 4'($urandom), $urandom, $urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        n_assert++;
        if ({bus.cdb_valid, bus.fu_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid got valid=%b ready=%b exp 0 000", bus.cdb_valid, bus.fu_ready);
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_assert++;
            if (bus.cdb_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_stale cyc=%0d got valid=%b tag=%0d exp 0", c, bus.cdb_valid, bus.cdb_tag);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst          = ($urandom_range(0, 99) < 1);
            bus.flush    = ($urandom_range(0, 99) < 4);
            bus.wb_stall = ($urandom_range(0, 99) < 25);
            for (int i = 0; i < NUM_FU; i++)
                drive_fu(i, $urandom_range(0, 99) < 60, 4'($urandom), $urandom, $urandom);
            #1;
            n_assert++;
            if (bus.fu_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, bus.fu_ready, exp_ready());
            end
            tick();
            n_assert++;
            if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src} !==
                {e_valid, e_ent.data, e_ent.tag, e_ent.pc, e_src}) begin
                n_fail++;
                $display("FAIL rand_cdb cyc=%0d got v=%b d=%h t=%0d pc=%h s=%0d exp v=%b d=%h t=%0d pc=%h s=%0d",
                         cyc, bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_pc, bus.cdb_src,
                         e_valid, e_ent.data, e_ent.tag, e_ent.pc, e_src);
            end
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
